// File: rtl/spi_master_multi.sv
// spi_master_multi: multi-CS SPI master with CS setup/hold and bursts; `SPI_MASTER_LOOPBACK_EN adds i_Loopback
module spi_master_multi #(
  parameter int DATA_WIDTH   = 8,
  parameter int CS_COUNT     = 1,
  parameter int CLKDIV_WIDTH = 8,
  parameter int CS_IDX_W     = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Cfg_CPOL,
  input  logic                    i_Cfg_CPHA,
  input  logic                    i_Cfg_Lsb_First,
  input  logic [CLKDIV_WIDTH-1:0] i_Cfg_Half_Bit,
  input  logic [CS_IDX_W-1:0]     i_CS_Sel,
  input  logic [DATA_WIDTH-1:0]   i_TX_Word,
  input  logic                    i_TX_DV,
  input  logic                    i_TX_Last,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                    i_Loopback,
`endif
  output logic                    o_TX_Ready,
  output logic                    o_RX_DV,
  output logic [DATA_WIDTH-1:0]   o_RX_Word,
  output logic                    o_Busy,
  output logic                    o_SPI_Clk,
  input  logic                    i_SPI_MISO,
  output logic                    o_SPI_MOSI,
  output logic [CS_COUNT-1:0]     o_SPI_CS_n
);
  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, WAIT, CS_HOLD, CS_GAP} state_t;
  state_t state;
  logic [CLKDIV_WIDTH-1:0] div, h;
  logic [EW-1:0] n;
  logic [DATA_WIDTH-1:0] tx, rx, rx_next;
  logic [BW-1:0] bi;
  logic cpol, cpha, lsb, last, accept, wrap, lead, smp, drv, fin, miso;
  function automatic logic [BW-1:0] pos(input logic l, input logic [BW-1:0] i);
    return l ? i : BW'(DATA_WIDTH - 1) - i;
  endfunction
`ifdef SPI_MASTER_LOOPBACK_EN
  assign miso = i_Loopback ? o_SPI_MOSI : i_SPI_MISO;
`else
  assign miso = i_SPI_MISO;
`endif
  assign accept = i_TX_DV & o_TX_Ready;
  assign wrap   = div == h - CLKDIV_WIDTH'(1);
  // n counts edges already emitted, so the edge about to fire is leading when n is even
  assign lead   = ~n[0];
  assign fin    = n == EW'(2 * DATA_WIDTH - 1);
  assign smp    = cpha ? ~lead : lead;
  assign drv    = cpha ? lead : ~lead & ~fin;
  assign bi     = BW'(n >> 1);
  always_comb begin
    rx_next = rx;
    if (smp) rx_next[pos(lsb, bi)] = miso;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= IDLE;
      div        <= '0;
      h          <= CLKDIV_WIDTH'(1);
      n          <= '0;
      tx         <= '0;
      rx         <= '0;
      cpol       <= 1'b0;
      cpha       <= 1'b0;
      lsb        <= 1'b0;
      last       <= 1'b0;
      o_TX_Ready <= 1'b0;
      o_RX_DV    <= 1'b0;
      o_RX_Word  <= '0;
      o_Busy     <= 1'b0;
      o_SPI_Clk  <= 1'b0;
      o_SPI_MOSI <= 1'b0;
      o_SPI_CS_n <= '1;
    end else begin
      o_RX_DV <= 1'b0;
      div     <= wrap ? '0 : div + CLKDIV_WIDTH'(1);
      case (state)
        IDLE, WAIT: begin
          o_SPI_Clk  <= state == IDLE ? i_Cfg_CPOL : cpol;
          o_TX_Ready <= ~accept;
          o_Busy     <= o_Busy | accept;
          if (accept) begin
            tx         <= i_TX_Word;
            last       <= i_TX_Last;
            div        <= '0;
            state      <= CS_SETUP;
            o_SPI_MOSI <= i_TX_Word[pos(state == IDLE ? i_Cfg_Lsb_First : lsb, BW'(0))];
            if (state == IDLE) begin
              cpol       <= i_Cfg_CPOL;
              cpha       <= i_Cfg_CPHA;
              lsb        <= i_Cfg_Lsb_First;
              h          <= i_Cfg_Half_Bit == '0 ? CLKDIV_WIDTH'(1) : i_Cfg_Half_Bit;
              o_SPI_CS_n <= ~(CS_COUNT'(1) << i_CS_Sel);
            end
          end
        end
        CS_SETUP, SHIFT: if (wrap) begin
          o_SPI_Clk <= ~o_SPI_Clk;
          n         <= n + EW'(1);
          rx        <= rx_next;
          state     <= SHIFT;
          if (drv) o_SPI_MOSI <= tx[pos(lsb, cpha ? bi : bi + BW'(1))];
          if (fin) begin
            n          <= '0;
            o_RX_DV    <= 1'b1;
            o_RX_Word  <= rx_next;
            o_TX_Ready <= ~last;
            state      <= last ? CS_HOLD : WAIT;
          end
        end
        CS_HOLD: if (wrap) begin
          o_SPI_CS_n <= '1;
          state      <= CS_GAP;
        end
        CS_GAP: if (wrap) begin
          o_Busy     <= 1'b0;
          o_TX_Ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: randomized bench with an SPI slave/monitor reference model
module tb_spi_master_multi;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cpol_i = 1'b0, cpha_i = 1'b0, lsb_i = 1'b0, dv = 1'b0, last_i = 1'b0, miso = 1'b0;
  logic [7:0] half_i = 8'd1, word_i = 8'd0;
  logic [2:0] sel_i = 3'd0;
  logic ready, rx_dv, busy, sclk, mosi;
  logic [7:0] rx_word;
  logic [3:0] cs_n;
  always #5 clk = ~clk;
  spi_master_multi #(.DATA_WIDTH(8), .CS_COUNT(4), .CLKDIV_WIDTH(8), .CS_IDX_W(3)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Cfg_CPOL(cpol_i), .i_Cfg_CPHA(cpha_i),
    .i_Cfg_Lsb_First(lsb_i), .i_Cfg_Half_Bit(half_i), .i_CS_Sel(sel_i),
    .i_TX_Word(word_i), .i_TX_DV(dv), .i_TX_Last(last_i), .o_TX_Ready(ready),
    .o_RX_DV(rx_dv), .o_RX_Word(rx_word), .o_Busy(busy), .o_SPI_Clk(sclk),
    .i_SPI_MISO(miso), .o_SPI_MOSI(mosi), .o_SPI_CS_n(cs_n)
  );
  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic bitof(input logic [7:0] w, input int i, input logic l);
    return l ? w[i] : w[7-i];
  endfunction
  logic m_cpol, m_cpha, m_lsb;
  int m_h;
  logic [3:0] m_cs = 4'hF;
  logic [7:0] exp_tx[$], exp_rx[$], slave_q[$];
  logic [7:0] tw[3], sw_arr[3];
  int cyc = 0, edges = 0, all_edges = 0, rx_cnt = 0, cs_falls = 0, cs_rises = 0;
  int t_cs_fall = 0, t_cs_rise = 0, t_ffirst = 0, t_last = 0, t_prev = 0;
  int spacing_err = 0, data_err = 0, cs_bad = 0, ci = 0, si = 0;
  logic loaded = 1'b0, pend = 1'b0, sclk_at_fall = 1'b0, lead, smp, prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic [7:0] cap = 8'd0, sw = 8'd0;
  logic [3:0] prev_cs = 4'hF;
  // Slave + monitor: drives MISO from slave_q and rebuilds MOSI words from the sample edges
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (!rst_n) begin
      edges = 0; ci = 0; loaded = 1'b0; pend = 1'b0;
    end else begin
      if (cs_n !== prev_cs) begin
        if (prev_cs === 4'hF) begin cs_falls++; t_cs_fall = cyc; sclk_at_fall = sclk; pend = 1'b1; end
        if (cs_n === 4'hF) begin cs_rises++; t_cs_rise = cyc; end
      end
      if (cs_n !== 4'hF && cs_n !== m_cs) cs_bad++;
      if (busy && sclk !== prev_sclk) begin
        lead = sclk != m_cpol;
        smp = lead != m_cpha;
        edges++; all_edges++;
        if (pend) begin t_ffirst = cyc; pend = 1'b0; end
        if (edges > 1 && cyc - t_prev != m_h) spacing_err++;
        t_prev = cyc;
        if (smp) begin
          if (mosi !== prev_mosi) data_err++;
          if (ci < 8) cap[m_lsb ? ci : 7 - ci] = mosi;
          ci++;
        end else if (si < 8) begin
          miso = bitof(sw, si, m_lsb);
          si++;
        end
        if (edges == 16) begin
          t_last = cyc;
          if (exp_tx.size() > 0) check("mosi_word", cap, exp_tx.pop_front());
          else check("mosi_extra", 1, 0);
          edges = 0; ci = 0; loaded = 1'b0;
        end
      end else if (edges > 0 && mosi !== prev_mosi) data_err++;
      if (rx_dv) begin
        rx_cnt++;
        if (exp_rx.size() > 0) check("rx_word", rx_word, exp_rx.pop_front());
        else check("rx_extra", 1, 0);
      end
      if (!loaded && edges == 0 && slave_q.size() > 0) begin
        sw = slave_q.pop_front();
        miso = bitof(sw, 0, m_lsb);
        si = m_cpha ? 0 : 1;
        loaded = 1'b1;
      end
    end
    prev_sclk = sclk; prev_mosi = mosi; prev_cs = cs_n;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic send(input logic [7:0] w, input logic l);
    int k = 0;
    while (!ready && k < 2000) begin @(negedge clk); k++; end
    check("send_ready", ready, 1);
    word_i = w; last_i = l; dv = 1'b1;
    exp_tx.push_back(w);
    @(negedge clk);
    dv = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3000) begin @(negedge clk); k++; end
    check("idle_timeout", busy, 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic setup(input logic cp, input logic ch, input logic l, input logic [7:0] hb, input logic [2:0] sel, input int n);
    m_cpol = cp; m_cpha = ch; m_lsb = l;
    m_h = hb == 0 ? 1 : int'(hb);
    m_cs = sel < 4 ? 4'hF ^ (4'b1 << sel) : 4'hF;
    cpol_i = cp; cpha_i = ch; lsb_i = l; half_i = hb; sel_i = sel;
    for (int i = 0; i < n; i++) begin slave_q.push_back(sw_arr[i]); exp_rx.push_back(sw_arr[i]); end
    repeat (3) @(negedge clk);
  endtask
  task automatic run(input logic cp, input logic ch, input logic l, input logic [7:0] hb,
                     input logic [2:0] sel, input int n, input bit poke, input bit chsel);
    int r0, e0, f0, q0, s0, d0, c0, k;
    setup(cp, ch, l, hb, sel, n);
    r0 = rx_cnt; e0 = all_edges; f0 = cs_falls; q0 = cs_rises; s0 = spacing_err; d0 = data_err; c0 = cs_bad;
    for (int i = 0; i < n; i++) begin
      send(tw[i], i == n - 1);
      if (i == 0) begin
        check("busy_frame", busy, 1);
        if (chsel) sel_i = sel ^ 3'd1;
        if (poke) begin
          k = 0;
          while (edges < 4 && k < 500) begin @(negedge clk); k++; end
          check("ready_shift", ready, 0);
          word_i = 8'hFF; last_i = 1'b1; dv = 1'b1;
          @(negedge clk);
          dv = 1'b0;
        end
      end
    end
    wait_idle();
    check("rx_cnt", rx_cnt - r0, n);
    check("edge_cnt", all_edges - e0, 16 * n);
    check("edge_spacing", spacing_err - s0, 0);
    check("data_edges", data_err - d0, 0);
    check("cs_pattern", cs_bad - c0, 0);
    check("cs_falls", cs_falls - f0, sel < 4);
    check("cs_rises", cs_rises - q0, sel < 4);
    check("tx_left", exp_tx.size(), 0);
    check("rx_left", exp_rx.size(), 0);
    if (sel < 4) begin
      check("sclk_idle", sclk_at_fall, cp);
      check("cs_setup", t_ffirst - t_cs_fall, m_h);
      check("cs_hold", t_cs_rise - t_last, m_h);
    end
  endtask
  initial begin
    int n, r0, k;
    repeat (3) @(negedge clk);
    check("rst_cs", cs_n, 4'hF);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ready", ready, 0);
    check("rst_rxdv", rx_dv, 0);
    check("rst_rxword", rx_word, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", ready, 1);
    @(negedge clk);
    tw[0] = 8'hA5; sw_arr[0] = 8'h3C;
    run(0, 0, 0, 8'd2, 3'd0, 1, 0, 0);
    for (int m = 1; m < 4; m++) begin
      tw[0] = 8'h81; sw_arr[0] = 8'h81;
      run(m[1], m[0], 1, 8'd3, 3'd0, 1, 0, 0);
    end
    tw[0] = 8'h11; tw[1] = 8'h22; tw[2] = 8'h33;
    for (int i = 0; i < 3; i++) sw_arr[i] = 8'($urandom);
    run(0, 0, 0, 8'd2, 3'd2, 3, 0, 1);
    tw[0] = 8'h5A; sw_arr[0] = 8'($urandom);
    run(0, 1, 0, 8'd2, 3'd1, 1, 1, 0);
    tw[0] = 8'($urandom); sw_arr[0] = 8'($urandom);
    run(1, 0, 0, 8'd0, 3'd5, 1, 0, 0);
    tw[0] = 8'($urandom); sw_arr[0] = 8'($urandom);
    setup(0, 0, 0, 8'd2, 3'd1, 1);
    send(tw[0], 1'b1);
    k = 0;
    while (edges < 7 && k < 500) begin @(negedge clk); k++; end
    check("reach_edge7", edges >= 7, 1);
    r0 = rx_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_cs", cs_n, 4'hF);
    check("abort_sclk", sclk, 0);
    check("abort_rxdv", rx_dv, 0);
    repeat (3) @(negedge clk);
    exp_tx.delete(); exp_rx.delete(); slave_q.delete();
    check("abort_no_rx", rx_cnt - r0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_abort", ready, 1);
    @(negedge clk);
    repeat (10) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin tw[i] = 8'($urandom); sw_arr[i] = 8'($urandom); end
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 3)), 3'($urandom_range(0, 5)), n, 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
